// File: rtl/zimbo_memctl_if.sv
// zimbo_memctl_if: core-side request bus and memory-side access bus of zimbo_memctl
interface zimbo_memctl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              core_rd;
  logic              core_wr;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic [DATA_W-1:0] core_rdata;
  logic              core_stall;
  logic              core_done;
  logic              core_err;
  logic              err_clr;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic [7:0]        last_wait;
  modport master (
    input  core_rd, core_wr, core_addr, core_wdata, err_clr, mem_rdata, mem_ack,
    output core_rdata, core_stall, core_done, core_err, mem_req, mem_we, mem_addr, mem_wdata, last_wait
  );
  modport slave (
    output core_rd, core_wr, core_addr, core_wdata, err_clr, mem_rdata, mem_ack,
    input  core_rdata, core_stall, core_done, core_err, mem_req, mem_we, mem_addr, mem_wdata, last_wait
  );
endinterface

// File: rtl/zimbo_memctl.sv
// zimbo_memctl: single-outstanding memory access controller with wait counting and sticky timeout
module zimbo_memctl #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15
) (
  input logic           clock,
  input logic           reset,
  zimbo_memctl_if.master bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  localparam logic [7:0] TMO = 8'(TIMEOUT);
  state_t            state_q, state_d;
  logic [7:0]        wait_q, wait_d, last_q, last_d;
  logic [DATA_W-1:0] rdata_q, rdata_d, wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d, err_q, err_d;
  logic              req, start, ack, tmo;
  assign req   = bus.core_rd | bus.core_wr;
  assign start = (state_q == IDLE) & req;
  assign ack   = (state_q == ACCESS) & bus.mem_ack;
  assign tmo   = (state_q == ACCESS) & ~bus.mem_ack & (wait_q == TMO);
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      wait_q  <= '0;
      last_q  <= '0;
      rdata_q <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      last_q  <= last_d;
      rdata_q <= rdata_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = state_q == IDLE   ? (req ? ACCESS : IDLE) :
              state_q == ACCESS ? ((ack | tmo) ? DONE : ACCESS) : IDLE;
  end
  // ack beats timeout because tmo is qualified by mem_ack low
  always_comb begin
    addr_d  = start ? bus.core_addr : addr_q;
    wdata_d = start ? bus.core_wdata : wdata_q;
    we_d    = start ? bus.core_wr : we_q;
    wait_d  = state_q != ACCESS ? '0 :
              (~bus.mem_ack & (wait_q != 8'hff)) ? wait_q + 8'd1 : wait_q;
    last_d  = ack ? wait_q : tmo ? TMO : last_q;
    rdata_d = (ack & ~we_q) ? bus.mem_rdata : (tmo & ~we_q) ? '1 : rdata_q;
    err_d   = tmo | (err_q & ~bus.err_clr);
  end
  assign bus.mem_req    = state_q == ACCESS;
  assign bus.core_done  = state_q == DONE;
  assign bus.core_stall = reset ? req : (start | (state_q == ACCESS));
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.core_rdata = rdata_q;
  assign bus.core_err   = err_q;
  assign bus.last_wait  = last_q;
endmodule

// File: tb/tb_zimbo_memctl.sv
// tb_zimbo_memctl: randomized transaction-level check of zimbo_memctl against a reference model
module tb_zimbo_memctl;
  localparam int TMO = 15;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  logic [15:0] m_rdata = '0;
  logic [7:0]  m_last = '0;
  logic        m_err = 1'b0;
  zimbo_memctl_if #(.DATA_W(16), .ADDR_W(16)) bus ();
  zimbo_memctl #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(TMO)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic check_model();
    chk("rdata", 32'(bus.core_rdata), 32'(m_rdata));
    chk("last_wait", 32'(bus.last_wait), 32'(m_last));
    chk("err", 32'(bus.core_err), 32'(m_err));
  endtask
  // one access: ack raised in ACCESS cycle d (never if d > TMO), returns in the IDLE cycle after DONE
  task automatic xact(input logic rd, input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                      input int d, input logic [15:0] rv, input logic keep);
    int k = 0;
    logic to = d > TMO;
    bus.core_rd = rd;
    bus.core_wr = wr;
    bus.core_addr = addr;
    bus.core_wdata = wdata;
    bus.mem_ack = 1'b0;
    bus.err_clr = 1'b0;
    #1;
    chk("stall_req", 32'(bus.core_stall), 32'd1);
    chk("req_idle", 32'(bus.mem_req), 32'd0);
    tick();
    while (!bus.core_done && k < 40) begin
      chk("mem_req", 32'(bus.mem_req), 32'd1);
      chk("mem_addr", 32'(bus.mem_addr), 32'(addr));
      chk("mem_we", 32'(bus.mem_we), 32'(wr));
      chk("mem_wdata", 32'(bus.mem_wdata), 32'(wdata));
      chk("stall_acc", 32'(bus.core_stall), 32'd1);
      bus.mem_ack = (k == d);
      bus.mem_rdata = (k == d) ? rv : 16'($urandom);
      tick();
      k++;
    end
    bus.mem_ack = 1'b0;
    chk("latency", 32'(k), 32'(to ? TMO + 1 : d + 1));
    chk("done", 32'(bus.core_done), 32'd1);
    chk("stall_done", 32'(bus.core_stall), 32'd0);
    if (!wr) m_rdata = to ? 16'hffff : rv;
    m_last = to ? 8'(TMO) : 8'(d);
    if (to) m_err = 1'b1;
    check_model();
    if (!keep) begin
      bus.core_rd = 1'b0;
      bus.core_wr = 1'b0;
    end
    tick();
    chk("done_pulse", 32'(bus.core_done), 32'd0);
    chk("req_after", 32'(bus.mem_req), 32'd0);
  endtask
  task automatic gap(input int g);
    repeat (g) begin
      bus.err_clr = ($urandom_range(0, 3) == 0);
      bus.mem_ack = 1'($urandom);
      bus.mem_rdata = 16'($urandom);
      tick();
      if (bus.err_clr) m_err = 1'b0;
      chk("err_idle", 32'(bus.core_err), 32'(m_err));
      chk("noise_done", 32'(bus.core_done), 32'd0);
    end
    bus.err_clr = 1'b0;
    bus.mem_ack = 1'b0;
  endtask
  initial begin
    bus.core_rd = 1'b0;
    bus.core_wr = 1'b0;
    bus.core_addr = '0;
    bus.core_wdata = '0;
    bus.err_clr = 1'b0;
    bus.mem_rdata = '0;
    bus.mem_ack = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_req", 32'(bus.mem_req), 32'd0);
    chk("rst_we", 32'(bus.mem_we), 32'd0);
    chk("rst_done", 32'(bus.core_done), 32'd0);
    chk("rst_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("rst_stall", 32'(bus.core_stall), 32'd0);
    check_model();
    xact(1'b1, 1'b0, 16'h0010, 16'h0000, 0, 16'hbeef, 1'b0);
    xact(1'b0, 1'b1, 16'h0020, 16'h1234, 4, 16'h5555, 1'b0);
    xact(1'b1, 1'b0, 16'h0030, 16'h0000, 40, 16'h0000, 1'b0);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    m_err = 1'b0;
    chk("err_clr", 32'(bus.core_err), 32'd0);
    xact(1'b1, 1'b0, 16'h0031, 16'h0000, TMO, 16'hcafe, 1'b0);
    xact(1'b1, 1'b1, 16'h0032, 16'h0abc, 3, 16'h7777, 1'b0);
    xact(1'b1, 1'b0, 16'h0033, 16'h0000, 2, 16'h1111, 1'b1);
    xact(1'b1, 1'b0, 16'h0033, 16'h0000, 1, 16'h2222, 1'b0);
    bus.core_rd = 1'b1;
    bus.core_addr = 16'h0040;
    tick();
    repeat (3) tick();
    chk("rst_acc_req", 32'(bus.mem_req), 32'd1);
    reset = 1'b1;
    tick();
    chk("rst_drop_req", 32'(bus.mem_req), 32'd0);
    chk("rst_stall_hold", 32'(bus.core_stall), 32'd1);
    reset = 1'b0;
    bus.core_rd = 1'b0;
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 16'h9999;
    m_rdata = '0;
    m_last = '0;
    m_err = 1'b0;
    repeat (2) begin
      tick();
      chk("late_ack_done", 32'(bus.core_done), 32'd0);
      chk("late_ack_req", 32'(bus.mem_req), 32'd0);
    end
    bus.mem_ack = 1'b0;
    check_model();
    for (int i = 0; i < 40; i++) begin
      int op = $urandom_range(0, 2);
      logic keep = ($urandom_range(0, 3) == 0);
      xact(op != 1, op != 0, 16'($urandom), 16'($urandom), $urandom_range(0, 19), 16'($urandom), keep);
      if (!keep) gap($urandom_range(0, 2));
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
